// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: instruction-fetch pipeline stage with PC register, next-PC
// selection, IF/ID pipeline register, boot sequencing and a saturating
// counter of taken redirects.
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   StallF         hold the PC register
//   StallD         hold the IF/ID register
//   FlushD         replace IF/ID contents with a bubble
//   PCSrcE         branch/jump taken, resolved in Execute
//   PCTargetE      redirect target from Execute (low two bits ignored)
//   InstrF         instruction read combinationally from imem at PCF
//   PCF            current fetch address (registered)
//   PCPlus4F       PCF + 4 (combinational)
//   InstrD         IF/ID instruction (registered)
//   PCD            IF/ID PC (registered)
//   PCPlus4D       IF/ID PC + 4 (registered)
//   ValidD         IF/ID holds a real instruction (registered)
//   RedirectCount  taken redirects since reset, saturating (registered)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic [DATA_WIDTH-1:0] InstrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic [15:0]           RedirectCount
);

    localparam int unsigned CNT_W = 16;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
    localparam logic [CNT_W-1:0]      CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Decoded per-cycle control
    logic                  boot_c;
    logic                  redirect_c;
    logic                  flush_c;
    logic                  pc_load_c;
    logic                  ifid_load_c;
    logic                  cnt_inc_c;

    // Next-state values for the registered outputs
    logic [DATA_WIDTH-1:0] pc_nxt;
    logic [DATA_WIDTH-1:0] instr_d_nxt;
    logic [DATA_WIDTH-1:0] pc_d_nxt;
    logic [DATA_WIDTH-1:0] pc_plus4_d_nxt;
    logic                  valid_d_nxt;
    logic [CNT_W-1:0]      redirect_cnt_nxt;

    // Sequential PC increment, wraps modulo 2^DATA_WIDTH
    assign PCPlus4F = PCF + PC_STEP;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and control decode
    always_comb begin
        state_nxt  = state;
        boot_c     = 1'b0;
        redirect_c = 1'b0;
        case (state)
            ST_BOOT: begin
                // First cycle out of reset: Execute is not yet valid, so
                // any PCSrcE seen here is stale and must be ignored.
                boot_c    = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                redirect_c = PCSrcE;
                state_nxt  = ST_RUN;
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // Redirect implies a flush of the wrong-path instruction in IF/ID;
    // a taken redirect also overrides a PC stall.
    always_comb begin
        flush_c     = 1'b0;
        pc_load_c   = 1'b0;
        ifid_load_c = 1'b0;
        cnt_inc_c   = 1'b0;

        flush_c     = boot_c | FlushD | redirect_c;
        pc_load_c   = redirect_c | ~StallF;
        ifid_load_c = ~flush_c & ~StallD;
        cnt_inc_c   = redirect_c & (RedirectCount != CNT_MAX);
    end

    // Next PC selection: word-aligned target on redirect, else PC + 4
    always_comb begin
        pc_nxt = PCF;
        if (redirect_c) begin
            pc_nxt = PCTargetE & ALIGN_MASK;
        end else if (pc_load_c) begin
            pc_nxt = PCPlus4F;
        end
    end

    // IF/ID next contents: flush beats stall, stall beats load
    always_comb begin
        instr_d_nxt    = InstrD;
        pc_d_nxt       = PCD;
        pc_plus4_d_nxt = PCPlus4D;
        valid_d_nxt    = ValidD;
        if (flush_c) begin
            instr_d_nxt    = NOP_INSTR;
            pc_d_nxt       = '0;
            pc_plus4_d_nxt = '0;
            valid_d_nxt    = 1'b0;
        end else if (ifid_load_c) begin
            // With StallF set this re-latches the held PCF; deduplication
            // is left to the hazard unit.
            instr_d_nxt    = InstrF;
            pc_d_nxt       = PCF;
            pc_plus4_d_nxt = PCPlus4F;
            valid_d_nxt    = 1'b1;
        end
    end

    // Saturating redirect counter
    always_comb begin
        redirect_cnt_nxt = RedirectCount;
        if (cnt_inc_c) begin
            redirect_cnt_nxt = RedirectCount + CNT_W'(1);
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PCF <= RESET_PC;
        end else begin
            PCF <= pc_nxt;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else begin
            InstrD   <= instr_d_nxt;
            PCD      <= pc_d_nxt;
            PCPlus4D <= pc_plus4_d_nxt;
            ValidD   <= valid_d_nxt;
        end
    end

    // Redirect counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RedirectCount <= '0;
        end else begin
            RedirectCount <= redirect_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage: scoreboard bench for fetch_stage. A reference model steps
// on every rising edge and queues the expected register state; a monitor on
// the falling edge pops and compares. Directed scenarios plus random traffic.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [15:0] RedirectCount;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc4d;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4d;
    logic        m_valid;
    logic [15:0] m_cnt;
    logic        m_boot;
    logic        m_init = 1'b0;

    fetch_stage #(
        .DATA_WIDTH (32),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .PCSrcE        (PCSrcE),
        .PCTargetE     (PCTargetE),
        .InstrF        (InstrF),
        .PCF           (PCF),
        .PCPlus4F      (PCPlus4F),
        .InstrD        (InstrD),
        .PCD           (PCD),
        .PCPlus4D      (PCPlus4D),
        .ValidD        (ValidD),
        .RedirectCount (RedirectCount)
    );

    // Instruction memory contents as a pure function of address
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    assign InstrF = imem(PCF);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(10 * 200000);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural rules applied once per rising edge
    initial begin
        logic        redirect;
        logic [31:0] old_pc;
        exp_t        e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pc    = RST_PC;
                m_instr = NOP;
                m_pcd   = 32'h0;
                m_pc4d  = 32'h0;
                m_valid = 1'b0;
                m_cnt   = 16'h0;
                m_boot  = 1'b1;
                m_init  = 1'b1;
            end else if (m_init) begin
                redirect = PCSrcE && !m_boot;
                old_pc   = m_pc;
                if (m_boot || FlushD || redirect) begin
                    m_instr = NOP;
                    m_pcd   = 32'h0;
                    m_pc4d  = 32'h0;
                    m_valid = 1'b0;
                end else if (!StallD) begin
                    m_instr = imem(old_pc);
                    m_pcd   = old_pc;
                    m_pc4d  = old_pc + 32'd4;
                    m_valid = 1'b1;
                end
                if (redirect)     m_pc = {PCTargetE[31:2], 2'b00};
                else if (!StallF) m_pc = old_pc + 32'd4;
                if (redirect && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_boot = 1'b0;
            end
            if (m_init) begin
                e.pc    = m_pc;
                e.instr = m_instr;
                e.pcd   = m_pcd;
                e.pc4d  = m_pc4d;
                e.valid = m_valid;
                e.cnt   = m_cnt;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compare DUT state against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("sb_PCF",           PCF,                  e.pc);
                cmp("sb_PCPlus4F",      PCPlus4F,             e.pc + 32'd4);
                cmp("sb_InstrD",        InstrD,               e.instr);
                cmp("sb_PCD",           PCD,                  e.pcd);
                cmp("sb_PCPlus4D",      PCPlus4D,             e.pc4d);
                cmp("sb_ValidD",        32'(ValidD),          32'(e.valid));
                cmp("sb_RedirectCount", 32'(RedirectCount),   32'(e.cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        cmp("rst_PCF", PCF, RST_PC);
        cmp("rst_ValidD", 32'(ValidD), 32'h0);
        cmp("rst_InstrD", InstrD, NOP);
        cmp("rst_Count", 32'(RedirectCount), 32'h0);

        // Boot cycle: PCSrcE must be ignored
        rst_n  = 1'b1;
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0800;
        step();
        PCSrcE = 1'b0;
        cmp("boot_PCF", PCF, 32'h4);
        cmp("boot_ValidD", 32'(ValidD), 32'h0);
        cmp("boot_Count", 32'(RedirectCount), 32'h0);
        step();
        cmp("run_PCF", PCF, 32'h8);
        cmp("run_ValidD", 32'(ValidD), 32'h1);
        cmp("run_PCD", PCD, 32'h4);
        cmp("run_InstrD", InstrD, imem(32'h4));

        guard = 0;
        while (m_pc != 32'h10 && guard < 20) begin
            step();
            guard++;
        end
        cmp("reach_pc10", PCF, 32'h10);

        // Redirect with unaligned target
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0103;
        step();
        PCSrcE = 1'b0;
        cmp("redir_PCF", PCF, 32'h100);
        cmp("redir_InstrD", InstrD, NOP);
        cmp("redir_ValidD", 32'(ValidD), 32'h0);
        cmp("redir_Count", 32'(RedirectCount), 32'h1);

        // Reach PCF = 0x20, then full stall for three cycles
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_001C;
        step();
        PCSrcE = 1'b0;
        step();
        cmp("pre_stall_PCF", PCF, 32'h20);
        StallF = 1'b1;
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("stall_PCF", PCF, 32'h20);
            cmp("stall_PCD", PCD, 32'h1C);
            cmp("stall_InstrD", InstrD, imem(32'h1C));
        end
        StallF = 1'b0;
        StallD = 1'b0;
        step();
        cmp("resume_PCF", PCF, 32'h24);
        cmp("resume_PCD", PCD, 32'h20);

        // Redirect beats both stalls
        StallF = 1'b1;
        StallD = 1'b1;
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0200;
        step();
        idle_inputs();
        cmp("flush_stall_PCF", PCF, 32'h200);
        cmp("flush_stall_ValidD", 32'(ValidD), 32'h0);
        cmp("flush_stall_InstrD", InstrD, NOP);

        // StallF alone: IF/ID re-latches the held PC
        StallF = 1'b1;
        step();
        step();
        StallF = 1'b0;
        cmp("dup_PCF", PCF, 32'h200);
        cmp("dup_PCD", PCD, 32'h200);
        cmp("dup_ValidD", 32'(ValidD), 32'h1);

        // FlushD alone
        FlushD = 1'b1;
        step();
        FlushD = 1'b0;
        cmp("flushd_PCF", PCF, 32'h204);
        cmp("flushd_ValidD", 32'(ValidD), 32'h0);

        // PC wrap-around
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFE;
        step();
        PCSrcE = 1'b0;
        cmp("wrap_PCF", PCF, 32'hFFFF_FFFC);
        cmp("wrap_PCPlus4F", PCPlus4F, 32'h0);
        step();
        cmp("wrap_next_PCF", PCF, 32'h0);
        cmp("wrap_PCPlus4D", PCPlus4D, 32'h0);
        cmp("wrap_PCD", PCD, 32'hFFFF_FFFC);

        // Random traffic including occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            StallF    = ($urandom_range(0, 3) == 0);
            StallD    = ($urandom_range(0, 3) == 0);
            FlushD    = ($urandom_range(0, 7) == 0);
            PCSrcE    = ($urandom_range(0, 7) == 0);
            PCTargetE = $urandom;
            step();
        end
        rst_n = 1'b1;
        idle_inputs();
        step();

        // Saturation of the redirect counter
        PCSrcE = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            StallF    = $urandom_range(0, 1) == 1;
            PCTargetE = $urandom;
            step();
        end
        cmp("sat_Count", 32'(RedirectCount), 32'h0000_FFFF);
        step();
        cmp("sat_hold_Count", 32'(RedirectCount), 32'h0000_FFFF);

        // Reset wins over stall and redirect
        StallF    = 1'b1;
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0400;
        rst_n     = 1'b0;
        step();
        cmp("rst_mid_PCF", PCF, RST_PC);
        cmp("rst_mid_ValidD", 32'(ValidD), 32'h0);
        cmp("rst_mid_Count", 32'(RedirectCount), 32'h0);
        rst_n = 1'b1;
        idle_inputs();
        step();
        step();
        step();
        @(negedge clk);
        #1;
        cmp("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
